// File: rtl/fb_pkg.sv
// Framebuffer-wide types and geometry shared by the scanout path.
package fb_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  localparam int FB_W      = 640;
  localparam int FB_H      = 480;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int FB_ADDR_W = 19;
  localparam int PIXEL_W   = $bits(pixel_t);

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO: head is presented combinationally; flush empties it in one cycle.
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PIXEL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer sharing: scanout prefetch has priority below a FIFO
// watermark, the pixel writer takes the remaining RAM slots.
module fb_scanout_arbiter #(
  parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
  parameter int DATA_W     = fb_pkg::PIXEL_W,
  parameter int FB_PIXELS  = fb_pkg::FB_PIXELS,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_pop,
  output logic [DATA_W-1:0] disp_pixel,
  output logic              disp_valid,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_L  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0]       LOW_L    = (CW+1)'(LOW_WM);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);

  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       level;
  logic              room;
  logic              disp_rd;
  logic              wr_grant;
  logic              fifo_push;
  logic              fifo_pop;

  assign level = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign room  = (level < DEPTH_L);

  // Gated by rst_n so the RAM port stays quiet while reset is held.
  assign disp_rd  = rst_n && !frame_start && room && ((level < LOW_L) || !wr_valid);
  assign wr_grant = rst_n && wr_valid && !disp_rd;

  // Data returning during frame_start belongs to the old frame: blocking the
  // push here is what drops the stale read.
  assign fifo_push = inflight && !frame_start && !fifo_full;
  assign fifo_pop  = disp_pop && !frame_start;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    wr_ready  = 1'b0;
    if (disp_rd) begin
      ram_en   = 1'b1;
      ram_addr = rd_ptr;
    end else if (wr_grant) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      wr_ready  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      inflight <= disp_rd;
      if (disp_rd) rd_ptr <= (rd_ptr == LAST_PIX) ? '0 : rd_ptr + ADDR_W'(1);
      if (disp_pop && fifo_empty) underflow <= 1'b1;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (ram_rdata),
    .pop       (fifo_pop),
    .head      (disp_pixel),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign disp_valid = !fifo_empty;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed + random bench for fb_scanout_arbiter against a queue-based reference model.
module tb_fb_scanout_arbiter;

  localparam int TB_PIX = 37;
  localparam int DEPTH  = 8;
  localparam int LWM    = 4;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        disp_pop;
  logic [11:0] disp_pixel;
  logic        disp_valid;
  logic        underflow;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        ram_en;
  logic        ram_we;
  logic [18:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [11:0] q[$];
  logic [11:0] shadow [TB_PIX];
  bit          m_inflight;
  logic [11:0] m_data;
  int          m_ptr;
  bit          m_uf;
  bit          e_rd;
  bit          e_wg;

  fb_scanout_arbiter #(
    .ADDR_W     (19),
    .DATA_W     (12),
    .FB_PIXELS  (TB_PIX),
    .FIFO_DEPTH (DEPTH),
    .LOW_WM     (LWM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .disp_pop    (disp_pop),
    .disp_pixel  (disp_pixel),
    .disp_valid  (disp_valid),
    .underflow   (underflow),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency, preloaded with pixel = address.
  initial begin
    logic [11:0] ram [TB_PIX];
    for (int i = 0; i < TB_PIX; i++) ram[i] = 12'(i);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_en && int'(ram_addr) < TB_PIX) begin
        if (ram_we) ram[int'(ram_addr)] = ram_wdata;
        else        ram_rdata <= ram[int'(ram_addr)];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 0;
    m_data     = '0;
    m_ptr      = 0;
    m_uf       = 0;
  endtask

  task automatic model_check();
    int lvl;
    lvl  = q.size() + int'(m_inflight);
    e_rd = rst_n && !frame_start && lvl < DEPTH && (lvl < LWM || !wr_valid);
    e_wg = rst_n && wr_valid && !e_rd;
    chk("ram_en",     32'(ram_en),     32'(e_rd || e_wg));
    chk("ram_we",     32'(ram_we),     32'(e_wg));
    chk("wr_ready",   32'(wr_ready),   32'(e_wg));
    chk("disp_valid", 32'(disp_valid), 32'(q.size() != 0));
    chk("disp_pixel", 32'(disp_pixel), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("underflow",  32'(underflow),  32'(m_uf));
    if (e_rd) chk("rd_addr", 32'(ram_addr), 32'(m_ptr));
    if (e_wg) begin
      chk("wr_addr",  32'(ram_addr),  32'(wr_addr));
      chk("wr_wdata", 32'(ram_wdata), 32'(wr_data));
    end
  endtask

  task automatic model_update();
    if (!rst_n) return;
    if (e_wg) shadow[int'(wr_addr)] = wr_data;
    if (frame_start) begin
      model_reset();
    end else begin
      if (disp_pop) begin
        if (q.size() != 0) void'(q.pop_front());
        else m_uf = 1;
      end
      if (m_inflight) q.push_back(m_data);
      m_inflight = e_rd;
      if (e_rd) begin
        m_data = shadow[m_ptr];
        m_ptr  = (m_ptr + 1) % TB_PIX;
      end
    end
  endtask

  task automatic step(input logic fs, input logic pop, input logic wv,
                      input logic [18:0] wa, input logic [11:0] wd);
    @(negedge clk);
    frame_start = fs;
    disp_pop    = pop;
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    #1;
    model_check();
    @(posedge clk);
    model_update();
  endtask

  task automatic rand_step(input int fs_pct, input int pop_pct, input int wv_pct);
    step(($urandom_range(99, 0) < fs_pct), ($urandom_range(99, 0) < pop_pct),
         ($urandom_range(99, 0) < wv_pct),
         19'($urandom_range(TB_PIX - 1, 0)), 12'($urandom));
  endtask

  initial begin
    for (int i = 0; i < TB_PIX; i++) shadow[i] = 12'(i);
    model_reset();
    rst_n = 1'b0; frame_start = 0; disp_pop = 0; wr_valid = 0; wr_addr = '0; wr_data = '0;

    // held in reset, requests present: everything must stay quiet
    step(0, 1, 1, 19'h5, 12'h123);
    step(0, 0, 0, '0, '0);
    #2 rst_n = 1'b1;

    // idle writer: prefetch of addresses 0..7 then stall
    for (int i = 0; i < 12; i++) step(0, 0, 0, '0, '0);

    // full FIFO, writer gets slots; popping below the watermark preempts it
    for (int i = 0; i < 3; i++) step(0, 0, 1, 19'h10, 12'hABC);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 19'h10, 12'hABC);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 19'h10, 12'hABC);

    // pop every cycle under writer pressure, through the pointer wrap
    for (int i = 0; i < 60; i++) step(0, 1, 1, 19'($urandom_range(TB_PIX - 1, 0)), 12'($urandom));

    // frame_start with a read in flight and a pop in the same cycle
    step(1, 1, 0, '0, '0);
    step(0, 1, 0, '0, '0);            // empty FIFO pop right after restart
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);            // clears the sticky flag
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0);

    // random traffic
    for (int i = 0; i < 400; i++) rand_step(2, 50, 50);
    for (int i = 0; i < 100; i++) rand_step(1, 90, 80);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(0, 1, 1, 19'($urandom_range(TB_PIX - 1, 0)), 12'($urandom));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    model_check();
    step(0, 1, 1, 19'h3, 12'h777);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) rand_step(2, 60, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
